pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg_pkg.sv | 29 ++
 rtl/pipe_stage_reg_sat_counter.sv | 19 +
 rtl/pipe_stage_reg.sv | 104 ++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for pipeline-stage registers: payload field widths,
// the NOP payload, and the stage occupancy state encoding.
package pipe_stage_reg_pkg;

    localparam int ALU_OP_BUS_W   = 8;
    localparam int ALU_SEL_BUS_W  = 3;
    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;

    localparam int PAYLOAD_W_DEF = ALU_OP_BUS_W + ALU_SEL_BUS_W + 2 * REG_BUS_W
                                 + REG_ADDR_BUS_W + 1;

    localparam logic [ALU_OP_BUS_W-1:0]   EXE_NOP_OP    = 8'h00;
    localparam logic [ALU_SEL_BUS_W-1:0]  EXE_RES_NOP   = 3'b000;
    localparam logic [REG_BUS_W-1:0]      ZERO_WORD     = 32'h0000_0000;
    localparam logic [REG_ADDR_BUS_W-1:0] NOP_REG_ADDR  = 5'b00000;
    localparam logic                      WRITE_DISABLE = 1'b0;

    // Field order matches the instantiating stage's packing: aluop first (MSBs), wreg last.
    localparam logic [PAYLOAD_W_DEF-1:0] NOP_PAYLOAD_DEF =
        {EXE_NOP_OP, EXE_RES_NOP, ZERO_WORD, ZERO_WORD, NOP_REG_ADDR, WRITE_DISABLE};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register with a 2-entry skid buffer, synchronous
// flush to a NOP bubble, and a saturating backpressure counter.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no entry; out_valid=0, in_ready=1
// ST_FULL  | main holds one entry, skid empty
// ST_SKID  | main and skid both hold entries; in_ready=0
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                   PAYLOAD_W   = PAYLOAD_W_DEF,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = PAYLOAD_W'(NOP_PAYLOAD_DEF),
    parameter int                   CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [CNT_W-1:0]     stall_cnt
);

    stage_state_t          state_q, state_d;
    logic [PAYLOAD_W-1:0]  main_q, main_d;
    logic [PAYLOAD_W-1:0]  skid_q, skid_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_PAYLOAD;
            skid_q  <= NOP_PAYLOAD;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_PAYLOAD;
            skid_d  = NOP_PAYLOAD;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_valid && out_ready) begin
                        main_d = in_data;
                    end else if (in_valid) begin
                        state_d = ST_SKID;
                        skid_d  = in_data;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                        main_d  = NOP_PAYLOAD;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so in_data is not looked at.
                    if (out_ready) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                        skid_d  = NOP_PAYLOAD;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_PAYLOAD;
                    skid_d  = NOP_PAYLOAD;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != ST_SKID);
        out_valid = (state_q != ST_EMPTY);
    end

    assign out_data = main_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule
